adder_stream_rx: RTL and testbench
==================================

# adder_stream_rx

Receive side of the sequenced full-adder stream. Consumes the registered S/COUT outputs of the 4-state adder sequencer (phases: sum-only, carry-only, both), follows the same phase cycle, checks phase discipline, and packs the "both" phase {COUT,S} pairs of N consecutive frames into a parallel word. The word is offered to downstream logic over a valid/ready handshake. Sits directly after the sequencer, on the same clock.

## Interface

- N, 4, frames per output word (N ≥ 1); word width 2N
- CLK  in  1  system clock, rising edge
- RST  in  1  reset; synchronous, active-high
- start  in  1  same start pulse driven to the sequencer; sampled only in IDLE
- rst  in  1  frame abort, same signal driven to the sequencer; active-high
- S_in  in  1  sequencer S output
- COUT_in  in  1  sequencer COUT output
- clr_err  in  1  clears sticky error flags
- data_out  out  2N  packed word; frame i at [2i+1:2i], COUT at odd bit, S at even bit; frame 0 in LSBs
- valid  out  1  data_out holds an unconsumed word
- ready  in  1  downstream accepts data_out when valid & ready
- err  out  3  sticky: [0] zero-phase violation, [1] hold mismatch, [2] overrun
- phase  out  3  current state encoding (debug)

## Operation

- States: IDLE=0, ALIGN=1, SUM=2, CARRY=3, BOTH=4.
- IDLE: start=1 & rst=0 → ALIGN. Otherwise stay.
- ALIGN: absorbs the sequencer's one-cycle output register delay; → SUM unconditionally unless rst.
- SUM: capture s_hold←S_in; if COUT_in≠0 set err[0]. → CARRY.
- CARRY: capture c_hold←COUT_in; if S_in≠0 set err[0]. → BOTH.
- BOTH: if S_in≠s_hold or COUT_in≠c_hold set err[1]. Shift {COUT_in,S_in} into the top of a 2N-bit shift register (shift right by 2); increment frame count. → SUM.
- Word complete when the count reaches N-1 at a BOTH edge: count←0 and the assembled word, including the current pair, is offered to the output buffer on the same edge.
- Output buffer:
  - Empty, or valid&ready in the same cycle: load the word, valid=1.
  - valid=1 & ready=0: drop the new word, keep the old one, set err[2].
  - valid&ready with no completing word: valid←0; data_out holds its value.
- rst=1 in any state other than IDLE: → IDLE at that edge. Frame count, partial shift register, s_hold and c_hold are cleared. The output buffer and err are untouched. rst takes priority over start.
- start outside IDLE is ignored.
- clr_err=1 clears err at that edge. If an error event occurs on the same edge, the error event wins.
- RST=1 at any edge: state IDLE; count, shift register and holds are 0; data_out=0, valid=0, err=0, phase=0. RST overrides all other inputs.

## Timing

- All outputs are registered; there are no combinational input→output paths.
- Sequencer alignment: start sampled at edge k. The sequencer enters S1 at k and drives S at k+1. The receiver is in ALIGN during cycle k→k+1 and samples SUM at edge k+2. CARRY samples at k+3 and BOTH at k+4.
- First word: valid rises after edge k+1+3N (N=4: k+13).
- Steady state: one word every 3N cycles. A consumer that asserts ready within 3N-1 cycles of valid never causes an overrun.
- The err bit is visible the cycle after the offending sample edge.

## Structure

- Shared package adder_seq_pkg holds:
  - receiver state constants (3-bit)
  - err bit index constants
  - the sequencer's 2-bit phase constants, so transmitter and receiver share one definition
- One sub-module, adder_rx_outbuf: the single-entry valid/ready holding register with overrun detection. It is parameterised by width.
- Phase FSM, checks and shift register stay in the top module.

## Test plan

- N=4, start at edge 0, A=B=1, CIN=0 held 12 frames → per frame S: 0,0,0? no: S stream SUM=0, CARRY COUT=1, BOTH {1,0}; valid at edge 13 with data_out=8'hAA, err=0.
- A=1, B=0, CIN=1 then A=B=CIN=1 alternating every frame (inputs stable within each frame) → data_out=8'b11_10_11_10=8'hEE; with ready held high, valid re-asserts every 12 cycles.
- COUT_in forced to 1 during one SUM sample → err=3'b001 one cycle later; clr_err pulse → err=0; packing continues unaffected.
- ready=0 across two word completions → first word retained, err[2]=1 after the second completion edge; ready=1 → first word consumed, valid=0.
- rst asserted in CARRY of frame 2 → phase=0 next cycle; re-issue start → the next word contains only post-restart frames and arrives 13 cycles after start.
- RST asserted mid-word with valid=1 and err≠0 → data_out=0, valid=0, err=0, phase=0 after the edge; start in the same cycle as RST is ignored.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared definitions for the sequenced full-adder stream: receiver states,
// err bit positions and the transmitter's 2-bit phase encoding.
package adder_seq_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_ALIGN = 3'd1,
    RX_SUM   = 3'd2,
    RX_CARRY = 3'd3,
    RX_BOTH  = 3'd4
  } rx_state_e;

  localparam int ERR_W    = 3;
  localparam int ERR_ZERO = 0;
  localparam int ERR_HOLD = 1;
  localparam int ERR_OVR  = 2;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_SUM   = 2'd1,
    SEQ_CARRY = 2'd2,
    SEQ_BOTH  = 2'd3
  } seq_phase_e;

endpackage

// File: rtl/adder_rx_outbuf.sv
// Single-entry valid/ready holding register. A word arriving while the
// previous one is still unconsumed is dropped and flagged as an overrun.
module adder_rx_outbuf #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] word,
  input  logic         ready,
  output logic [W-1:0] data_out,
  output logic         valid,
  output logic         overrun
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    overrun = 1'b0;
    if (push) begin
      if (!valid_q || ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;

endmodule

// File: rtl/adder_stream_rx.sv
// Receiver for the sequenced full-adder stream: tracks the sequencer's phase
// cycle, checks phase discipline and packs N "both" pairs into a 2N-bit word.
module adder_stream_rx
  import adder_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             rst,
  input  logic             S_in,
  input  logic             COUT_in,
  input  logic             clr_err,
  output logic [2*N-1:0]   data_out,
  output logic             valid,
  input  logic             ready,
  output logic [ERR_W-1:0] err,
  output logic [2:0]       phase
);

  localparam int W  = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     sr_q, sr_d;
  logic             s_hold_q, s_hold_d;
  logic             c_hold_q, c_hold_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [W-1:0]     pair_w;
  logic [W-1:0]     word;
  logic             push;
  logic             ovr;
  logic [1:0]       chk_ev;

  // New pair enters at the top so frame 0 ends up in the LSBs after N shifts.
  always_comb begin
    pair_w        = '0;
    pair_w[W-1]   = COUT_in;
    pair_w[W-2]   = S_in;
    word          = (sr_q >> 2) | pair_w;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    s_hold_d = s_hold_q;
    c_hold_d = c_hold_q;
    chk_ev   = '0;
    push     = 1'b0;
    case (state_q)
      RX_IDLE:  if (start && !rst) state_d = RX_ALIGN;
      RX_ALIGN: state_d = RX_SUM;
      RX_SUM: begin
        s_hold_d         = S_in;
        chk_ev[ERR_ZERO] = COUT_in;
        state_d          = RX_CARRY;
      end
      RX_CARRY: begin
        c_hold_d         = COUT_in;
        chk_ev[ERR_ZERO] = S_in;
        state_d          = RX_BOTH;
      end
      RX_BOTH: begin
        chk_ev[ERR_HOLD] = (S_in != s_hold_q) || (COUT_in != c_hold_q);
        sr_d             = word;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d = '0;
          push  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        state_d = RX_SUM;
      end
      default: state_d = RX_IDLE;
    endcase
    // Frame abort discards the partial word; output buffer and err survive.
    if (rst && state_q != RX_IDLE) begin
      state_d  = RX_IDLE;
      cnt_d    = '0;
      sr_d     = '0;
      s_hold_d = 1'b0;
      c_hold_d = 1'b0;
      chk_ev   = '0;
      push     = 1'b0;
    end
  end

  always_comb begin
    err_d           = clr_err ? '0 : err_q;
    err_d[ERR_ZERO] = err_d[ERR_ZERO] | chk_ev[ERR_ZERO];
    err_d[ERR_HOLD] = err_d[ERR_HOLD] | chk_ev[ERR_HOLD];
    err_d[ERR_OVR]  = err_d[ERR_OVR]  | ovr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      s_hold_q <= 1'b0;
      c_hold_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      s_hold_q <= s_hold_d;
      c_hold_q <= c_hold_d;
      err_q    <= err_d;
    end
  end

  adder_rx_outbuf #(.W(W)) u_outbuf (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .word     (word),
    .ready    (ready),
    .data_out (data_out),
    .valid    (valid),
    .overrun  (ovr)
  );

  assign err   = err_q;
  assign phase = state_q;

endmodule

// File: tb/tb_adder_stream_rx.sv
// Bench for adder_stream_rx: plays the sequencer's phase schedule and checks
// packed words through a scoreboard plus per-scenario timing/flag checks.
module tb_adder_stream_rx;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         CLK = 1'b0;
  logic         RST, start, rst, S_in, COUT_in, clr_err, ready, valid;
  logic [W-1:0] data_out;
  logic [2:0]   err, phase;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] mw;
  int           mf;
  bit           drop_next;

  always #5 CLK = ~CLK;

  adder_stream_rx #(.N(N)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rst(rst), .S_in(S_in),
    .COUT_in(COUT_in), .clr_err(clr_err), .data_out(data_out),
    .valid(valid), .ready(ready), .err(err), .phase(phase)
  );

  // Consumption is decided at the coming rising edge; compare at the falling edge before it.
  task automatic tick;
    logic [W-1:0] e;
    @(negedge CLK);
    if (valid && ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_word got=%h want=none", data_out);
      end else begin
        e = q.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL sb_word got=%h want=%h", data_out, e);
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // fault: 0 none, 1 COUT high during SUM, 2 S flipped during BOTH
  task automatic do_frame(input logic s, input logic c, input int fault,
                          input logic clr, output logic [2:0] e_sum);
    logic sb;
    sb      = s ^ (fault == 2);
    S_in    = s;  COUT_in = (fault == 1); clr_err = clr;
    tick();
    e_sum   = err;
    clr_err = 1'b0;
    S_in    = 1'b0; COUT_in = c;
    tick();
    S_in    = sb;   COUT_in = c;
    tick();
    S_in    = 1'b0; COUT_in = 1'b0;
    mw = {c, sb, mw[W-1:2]};
    mf++;
    if (mf == N) begin
      mf = 0;
      if (!drop_next) q.push_back(mw);
      drop_next = 1'b0;
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic abort(input logic clr);
    rst = 1'b1; clr_err = clr;
    tick();
    rst = 1'b0; clr_err = 1'b0;
    mw = '0; mf = 0;
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b1;
    tick(); tick();
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
    total++; if (valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (err !== 3'b000)  begin bad++; $display("FAIL reset_err got=%b want=000", err); end
    total++; if (phase !== 3'd0)  begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
    RST = 1'b0; start = 1'b0;
    tick();
    total++; if (phase !== 3'd0)  begin bad++; $display("FAIL idle_hold_phase got=%0d want=0", phase); end
  endtask

  task automatic test_basic;
    logic [2:0] e;
    ready = 1'b1;
    do_start();
    total++; if (phase !== 3'd2) begin bad++; $display("FAIL basic_phase_sum got=%0d want=2", phase); end
    for (int f = 0; f < 3; f++) do_frame(1'b0, 1'b1, 0, 1'b0, e);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b want=0", valid); end
    do_frame(1'b0, 1'b1, 0, 1'b0, e);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL basic_valid_k13 got=%b want=1", valid); end
    total++; if (data_out !== 8'hAA) begin bad++; $display("FAIL basic_data got=%h want=aa", data_out); end
    total++; if (err !== 3'b000) begin bad++; $display("FAIL basic_err got=%b want=000", err); end
    for (int f = 4; f < 12; f++) do_frame(1'b0, 1'b1, 0, 1'b0, e);
    abort(1'b0);
  endtask

  task automatic test_back_to_back;
    logic [2:0] e;
    ready = 1'b1;
    do_start();
    for (int f = 0; f < 8; f++) begin
      do_frame(logic'(f % 2), 1'b1, 0, 1'b0, e);
      if (f == 3 || f == 7) begin
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_valid f=%0d got=%b want=1", f, valid); end
        total++; if (data_out !== 8'hEE) begin bad++; $display("FAIL b2b_data f=%0d got=%h want=ee", f, data_out); end
      end
      if (f == 4) begin
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop got=%b want=0", valid); end
      end
    end
    abort(1'b0);
  endtask

  task automatic test_zero_phase;
    logic [2:0] e;
    ready = 1'b1;
    do_start();
    do_frame(1'b1, 1'b0, 1, 1'b0, e);
    total++; if (e !== 3'b001) begin bad++; $display("FAIL zp_err_set got=%b want=001", e); end
    do_frame(1'b1, 1'b0, 0, 1'b1, e);
    total++; if (e !== 3'b000) begin bad++; $display("FAIL zp_err_clr got=%b want=000", e); end
    do_frame(1'b1, 1'b0, 0, 1'b0, e);
    do_frame(1'b1, 1'b0, 0, 1'b0, e);
    total++; if (err !== 3'b000) begin bad++; $display("FAIL zp_err_after got=%b want=000", err); end
    do_frame(1'b1, 1'b0, 2, 1'b0, e);
    total++; if (err !== 3'b010) begin bad++; $display("FAIL hold_err got=%b want=010", err); end
    for (int f = 5; f < 8; f++) do_frame(1'b1, 1'b0, 0, 1'b0, e);
    abort(1'b1);
    total++; if (err !== 3'b000) begin bad++; $display("FAIL hold_err_clr got=%b want=000", err); end
  endtask

  task automatic test_overrun;
    logic [2:0] e;
    ready = 1'b0;
    do_start();
    for (int f = 0; f < 4; f++) do_frame(1'b0, 1'b1, 0, 1'b0, e);
    for (int f = 0; f < 3; f++) do_frame(1'b1, 1'b1, 0, 1'b0, e);
    total++; if (err !== 3'b000) begin bad++; $display("FAIL ovr_err_early got=%b want=000", err); end
    drop_next = 1'b1;
    do_frame(1'b1, 1'b1, 0, 1'b0, e);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", valid); end
    total++; if (data_out !== 8'hAA) begin bad++; $display("FAIL ovr_keep_old got=%h want=aa", data_out); end
    total++; if (err !== 3'b100) begin bad++; $display("FAIL ovr_err got=%b want=100", err); end
    ready = 1'b1;
    abort(1'b0);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_consumed got=%b want=0", valid); end
    total++; if (data_out !== 8'hAA) begin bad++; $display("FAIL ovr_data_hold got=%h want=aa", data_out); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  task automatic test_abort;
    logic [2:0] e;
    ready = 1'b1;
    do_start();
    do_frame(1'b1, 1'b0, 0, 1'b0, e);
    do_frame(1'b1, 1'b0, 0, 1'b0, e);
    S_in = 1'b1; COUT_in = 1'b0;
    tick();
    S_in = 1'b0;
    abort(1'b0);
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL abort_phase got=%0d want=0", phase); end
    do_start();
    for (int f = 0; f < 3; f++) do_frame(1'b0, 1'b1, 0, 1'b0, e);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid_early got=%b want=0", valid); end
    do_frame(1'b0, 1'b1, 0, 1'b0, e);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL abort_valid_k13 got=%b want=1", valid); end
    total++; if (data_out !== 8'hAA) begin bad++; $display("FAIL abort_data got=%h want=aa", data_out); end
    abort(1'b0);
  endtask

  task automatic test_hard_reset;
    logic [2:0] e;
    ready = 1'b0;
    do_start();
    do_frame(1'b1, 1'b1, 1, 1'b0, e);
    for (int f = 1; f < 6; f++) do_frame(1'b1, 1'b1, 0, 1'b0, e);
    total++; if (valid !== 1'b1 || err !== 3'b001) begin
      bad++; $display("FAIL hr_pre got=valid %b err %b want=valid 1 err 001", valid, err);
    end
    RST = 1'b1; start = 1'b1;
    tick();
    total++; if (data_out !== '0) begin bad++; $display("FAIL hr_data got=%h want=00", data_out); end
    total++; if (valid !== 1'b0)  begin bad++; $display("FAIL hr_valid got=%b want=0", valid); end
    total++; if (err !== 3'b000)  begin bad++; $display("FAIL hr_err got=%b want=000", err); end
    total++; if (phase !== 3'd0)  begin bad++; $display("FAIL hr_phase got=%0d want=0", phase); end
    RST = 1'b0; start = 1'b0;
    tick();
    total++; if (phase !== 3'd0)  begin bad++; $display("FAIL hr_start_ignored got=%0d want=0", phase); end
    q.delete();
    mw = '0; mf = 0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; rst = 1'b0; S_in = 1'b0; COUT_in = 1'b0;
    clr_err = 1'b0; ready = 1'b0;
    mw = '0; mf = 0; drop_next = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_phase();
    test_overrun();
    test_abort();
    test_hard_reset();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d words want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
